// File: rtl/led_flasher.sv
// led_flasher: stretches single-cycle event pulses into visible LED flashes.
// Each flash lights the LED for ON_CYCLES clocks and then forces OFF_CYCLES of dark.
// Events arriving while a flash is running are counted in a saturating pending
// counter and replayed back-to-back. The overflow flag is sticky.
// Optional feature: define LED_FLASHER_STATS_EN to add a 16-bit flash_count output
// that counts completed ON phases. This counter is not cleared by 'clear'.
module led_flasher #(
    parameter int ON_CYCLES  = 12_500_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int CW         = 24,
    parameter int QW         = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          event_pulse,
    input  logic          clear,
    output logic          led,
    output logic          busy,
    output logic [QW-1:0] pending,
    output logic          overflow
`ifdef LED_FLASHER_STATS_EN
    ,
    output logic [15:0]   flash_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LAST  = CW'(OFF_CYCLES - 1);
    localparam logic [QW-1:0] PEND_MAX  = '1;

    state_t          state_q, state_d;
    logic [CW-1:0]   timer_q, timer_d;
    logic [QW-1:0]   pending_q, pending_d;
    logic            overflow_q, overflow_d;
    logic            led_q, busy_q;
    logic            enq, deq;
`ifdef LED_FLASHER_STATS_EN
    logic [15:0]     count_q, count_d;
`endif

    // Next-state logic: timer sequencing, flash chaining and pending-queue bookkeeping.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        enq        = 1'b0;
        deq        = 1'b0;
`ifdef LED_FLASHER_STATS_EN
        count_d    = count_q;
`endif
        if (clear) begin
            // Abort wins over any same-cycle event; that event is simply dropped.
            state_d    = IDLE;
            timer_d    = '0;
            pending_d  = '0;
            overflow_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (event_pulse) begin
                        state_d = ON;
                        timer_d = '0;
                    end
                end
                ON: begin
                    enq = event_pulse;
                    if (timer_q == ON_LAST) begin
                        state_d = OFF;
                        timer_d = '0;
`ifdef LED_FLASHER_STATS_EN
                        count_d = count_q + 16'd1;
`endif
                    end else begin
                        timer_d = timer_q + CW'(1);
                    end
                end
                OFF: begin
                    enq = event_pulse;
                    if (timer_q == OFF_LAST) begin
                        timer_d = '0;
                        if (pending_q != '0) begin
                            // Queued work is served first; a same-cycle event then just re-fills the slot.
                            state_d = ON;
                            deq     = 1'b1;
                        end else if (event_pulse) begin
                            // Event on the final dark cycle starts the next flash directly.
                            state_d = ON;
                            enq     = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        timer_d = timer_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase

            if (enq && !deq) begin
                if (pending_q == PEND_MAX) begin
                    overflow_d = 1'b1;
                end else begin
                    pending_d = pending_q + QW'(1);
                end
            end else if (deq && !enq) begin
                pending_d = pending_q - QW'(1);
            end
        end
    end

    // State, timer, queue and registered LED/busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
`ifdef LED_FLASHER_STATS_EN
            count_q    <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            led_q      <= (state_d == ON);
            busy_q     <= (state_d != IDLE);
`ifdef LED_FLASHER_STATS_EN
            count_q    <= count_d;
`endif
        end
    end

    assign led      = led_q;
    assign busy     = busy_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;
`ifdef LED_FLASHER_STATS_EN
    assign flash_count = count_q;
`endif

endmodule

// File: tb/tb_led_flasher.sv
// Testbench for led_flasher (ON_CYCLES=4, OFF_CYCLES=2, CW=4, QW=2).
// The reference model tracks each flash by its start cycle and derives the LED
// from elapsed time. Expected outputs are queued per clock edge, and a negedge
// monitor compares them against the DUT.
module tb_led_flasher;

    localparam int ON   = 4;
    localparam int OFF  = 2;
    localparam int CW   = 4;
    localparam int QW   = 2;
    localparam int PMAX = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          event_pulse = 1'b0;
    logic          clear = 1'b0;
    logic          led;
    logic          busy;
    logic [QW-1:0] pending;
    logic          overflow;
`ifdef LED_FLASHER_STATS_EN
    logic [15:0]   flash_count;
`endif

    always #5 clk = ~clk;

    led_flasher #(
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .CW        (CW),
        .QW        (QW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .event_pulse(event_pulse),
        .clear      (clear),
        .led        (led),
        .busy       (busy),
        .pending    (pending),
        .overflow   (overflow)
`ifdef LED_FLASHER_STATS_EN
        ,
        .flash_count(flash_count)
`endif
    );

    typedef struct {
        int cyc;
        bit led;
        bit busy;
        int pend;
        bit ovf;
        int fc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state. A flash is described by its start cycle.
    int   cyc = 0;
    int   m_start = 0;
    int   m_pend = 0;
    int   m_fc = 0;
    bit   m_active = 1'b0;
    bit   m_ovf = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_pend   = 0;
        m_ovf    = 1'b0;
        m_fc     = 0;
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_edge(bit ev, bit clr);
        int age;
        bit ev_left;
        cyc++;
        ev_left = ev;
        if (clr) begin
            m_active = 1'b0;
            m_pend   = 0;
            m_ovf    = 1'b0;
            ev_left  = 1'b0;
        end else if (!m_active) begin
            if (ev) begin
                m_active = 1'b1;
                m_start  = cyc;
            end
            ev_left = 1'b0;
        end else begin
            age = cyc - 1 - m_start;
            if (age == ON + OFF - 1) begin
                if (m_pend > 0) begin
                    m_pend--;
                    m_start = cyc;
                end else if (ev) begin
                    m_start = cyc;
                    ev_left = 1'b0;
                end else begin
                    m_active = 1'b0;
                end
            end
            if (ev_left) begin
                if (m_pend == PMAX) m_ovf = 1'b1;
                else m_pend++;
            end
            if (m_active && (cyc - m_start) == ON) m_fc = (m_fc + 1) % 65536;
        end
    endtask

    // Drive one cycle of stimulus and queue the expected post-edge outputs.
    task automatic step(bit ev, bit clr);
        exp_t e;
        event_pulse = ev;
        clear       = clr;
        model_edge(ev, clr);
        e.cyc  = cyc;
        e.led  = m_active && ((cyc - m_start) < ON);
        e.busy = m_active;
        e.pend = m_pend;
        e.ovf  = m_ovf;
        e.fc   = m_fc;
        @(posedge clk);
        sb_q.push_back(e);
        #1;
        event_pulse = 1'b0;
        clear       = 1'b0;
    endtask

    // Monitor: compare every queued expectation away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            $display("cyc=%0d led=%0b busy=%0b pending=%0d overflow=%0b", e.cyc, led, busy, pending, overflow);
            check("led", 32'(led), 32'(e.led));
            check("busy", 32'(busy), 32'(e.busy));
            check("pending", 32'(pending), 32'(e.pend));
            check("overflow", 32'(overflow), 32'(e.ovf));
`ifdef LED_FLASHER_STATS_EN
            check("flash_count", 32'(flash_count), 32'(e.fc));
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_led", 32'(led), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_pending", 32'(pending), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
`ifdef LED_FLASHER_STATS_EN
        check("reset_flash_count", 32'(flash_count), 32'd0);
`endif
        rst_n = 1'b1;

        // Single flash, taken on the first edge after reset release
        step(1, 0);
        repeat (8) step(0, 0);

        // Three events, two of which get queued
        step(1, 0); step(0, 0); step(1, 0); step(1, 0);
        repeat (20) step(0, 0);

        // Saturation and sticky overflow
        step(1, 0);
        repeat (4) step(1, 0);
        repeat (30) step(0, 0);

        // Event on the last OFF cycle with an empty queue
        step(1, 0);
        repeat (5) step(0, 0);
        step(1, 0);
        repeat (10) step(0, 0);

        // Clear and event together during ON with pending=2
        step(1, 0); step(1, 0); step(1, 0);
        step(1, 1);
        repeat (10) step(0, 0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            bit ev;
            bit clr;
            ev  = ($urandom_range(0, 99) < 35);
            clr = ($urandom_range(0, 99) < 3);
            step(ev, clr);
        end
        repeat (12) step(0, 0);

        // Asynchronous reset in the middle of an ON phase
        step(1, 0);
        repeat (3) step(1, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(led), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_pending", 32'(pending), 32'd0);
        check("async_rst_overflow", 32'(overflow), 32'd0);
`ifdef LED_FLASHER_STATS_EN
        check("async_rst_flash_count", 32'(flash_count), 32'd0);
`endif
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Three isolated flashes after reset
        repeat (3) begin
            step(1, 0);
            repeat (6) step(0, 0);
        end
        repeat (4) step(0, 0);

        // Let the monitor consume the remaining expectations
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
